// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared FSM states, sync byte, error codes and FIFO entry type for the boot loader.
package boot_loader_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DRAIN, S_BOOT, S_ERROR
  } state_e;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_LEN  = 2'd3;
  // Address field is sized for the widest supported ICCM; the top truncates to AddrW.
  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } entry_t;
endpackage

// File: rtl/boot_word_fifo.sv
// boot_word_fifo: synchronous FIFO of {addr, data} entries with a combinational head view.
module boot_word_fifo
  import boot_loader_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t din_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);
  localparam int PW = $clog2(Depth);
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic        wr_en;
  entry_t      mem_q [Depth];
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q ^ rd_q) == {1'b1, {PW{1'b0}}};
  assign head_o  = mem_q[rd_q[PW-1:0]];
  always_comb begin
    wr_en = push_i && (!full_o || pop_i);
    wr_d  = wr_q + (PW+1)'(wr_en);
    rd_d  = rd_q + (PW+1)'(pop_i && !empty_o);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[PW-1:0]] <= din_i;
  end
endmodule

// File: rtl/boot_frame_loader.sv
// boot_frame_loader: parses checksummed load frames, queues words for ICCM and releases core reset on a boot frame.
// Optional inter-byte timeout enabled by defining BOOT_LOADER_TIMEOUT_EN.
module boot_frame_loader
  import boot_loader_pkg::*;
#(
  parameter int AddrW         = 12,
  parameter int FifoDepth     = 4,
  parameter int TimeoutCycles = 65535
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_dv_i,
  input  logic [7:0]       rx_byte_i,
  output logic             we_o,
  output logic [AddrW-1:0] addr_o,
  output logic [31:0]      wdata_o,
  input  logic             gnt_i,
  output logic             core_rst_no,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);
  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [15:0]      len_q, len_d, word_cnt_q, word_cnt_d, word_cnt_nxt;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       csum_q, csum_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             push, pop, full, empty;
  logic [16:0]      len_full;
  entry_t           head, push_entry;
`ifdef BOOT_LOADER_TIMEOUT_EN
  logic [31:0]      tmo_q, tmo_d;
`endif
  boot_word_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );
  assign pop          = !empty && gnt_i;
  assign we_o         = !empty;
  assign addr_o       = empty ? '0 : head.addr[AddrW-1:0];
  assign wdata_o      = empty ? '0 : head.data;
  assign done_o       = state_q == S_BOOT;
  assign core_rst_no  = state_q == S_BOOT;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign len_full     = {1'b0, rx_byte_i, len_q[7:0]};
  assign word_cnt_nxt = word_cnt_q + 16'd1;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    csum_d     = csum_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    push       = 1'b0;
    push_entry = '{addr: 16'(addr_q), data: {rx_byte_i, word_q[31:8]}};
    if (rx_dv_i) begin
      csum_d = csum_q + rx_byte_i;
      case (state_q)
        S_IDLE, S_ERROR: if (rx_byte_i == SYNC_BYTE) begin
          state_d    = S_ADDR0;
          csum_d     = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
        S_ADDR0: begin
          addr_d  = AddrW'(rx_byte_i);
          state_d = S_ADDR1;
        end
        S_ADDR1: begin
          addr_d  = AddrW'({rx_byte_i, addr_q[7:0]});
          state_d = S_LEN0;
        end
        S_LEN0: begin
          len_d   = {8'h00, rx_byte_i};
          state_d = S_LEN1;
        end
        S_LEN1: begin
          len_d      = len_full[15:0];
          byte_cnt_d = '0;
          word_cnt_d = '0;
          state_d    = len_full > (17'd1 << AddrW) ? S_ERROR : len_full == '0 ? S_CSUM : S_DATA;
          err_d      = len_full > (17'd1 << AddrW);
          err_code_d = len_full > (17'd1 << AddrW) ? ERR_LEN : err_code_q;
        end
        S_DATA: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {rx_byte_i, word_q[31:8]};
          if (byte_cnt_q == 2'd3) begin
            if (full && !pop) begin
              state_d    = S_ERROR;
              err_d      = 1'b1;
              err_code_d = ERR_OVF;
            end else begin
              push       = 1'b1;
              addr_d     = addr_q + AddrW'(1);
              word_cnt_d = word_cnt_nxt;
              state_d    = word_cnt_nxt == len_q ? S_CSUM : S_DATA;
            end
          end
        end
        S_CSUM: begin
          state_d    = rx_byte_i != csum_q ? S_ERROR : len_q == '0 ? S_DRAIN : S_IDLE;
          err_d      = rx_byte_i != csum_q;
          err_code_d = rx_byte_i != csum_q ? ERR_CSUM : err_code_q;
        end
        default: ;
      endcase
    end
    if (state_q == S_DRAIN && empty) state_d = S_BOOT;
`ifdef BOOT_LOADER_TIMEOUT_EN
    tmo_d = '0;
    if (!rx_dv_i && state_q inside {S_ADDR0, S_ADDR1, S_LEN0, S_LEN1, S_DATA, S_CSUM}) begin
      tmo_d = tmo_q + 32'd1;
      if (tmo_d >= 32'(TimeoutCycles)) begin
        tmo_d      = '0;
        state_d    = S_ERROR;
        err_d      = 1'b1;
        err_code_d = ERR_LEN;
      end
    end
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end
`ifdef BOOT_LOADER_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif
endmodule

// File: tb/tb_boot_frame_loader.sv
// tb_boot_frame_loader: directed and randomized frames checked against a frame-level write model.
module tb_boot_frame_loader;
  logic        clk_i = 0, rst_ni = 0, rx_dv_i = 0, gnt_i = 1;
  logic [7:0]  rx_byte_i = 0;
  logic        we_o, core_rst_no, done_o, err_o;
  logic [11:0] addr_o;
  logic [31:0] wdata_o;
  logic [1:0]  err_code_o;
  int          total = 0, bad = 0, low_run = 0;
  bit          rnd_gnt = 0;
  logic [43:0] obs[$], exp_q[$];
  logic [31:0] words[$];

  boot_frame_loader #(.AddrW(12), .FifoDepth(4), .TimeoutCycles(40)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_dv_i(rx_dv_i), .rx_byte_i(rx_byte_i),
    .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .gnt_i(gnt_i),
    .core_rst_no(core_rst_no), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (rst_ni && we_o && gnt_i) obs.push_back({addr_o, wdata_o});

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick(input bit dv, input logic [7:0] b);
    rx_dv_i = dv;
    rx_byte_i = b;
    if (rnd_gnt) begin
      gnt_i = ($urandom_range(0, 1) == 1) || low_run >= 2;
      low_run = gnt_i ? 0 : low_run + 1;
    end
    @(posedge clk_i);
    #1 rx_dv_i = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [7:0] cadj, input bit expect_wr);
    logic [7:0] fb[$];
    logic [7:0] cs = 0;
    fb = {a[7:0], a[15:8], 8'(words.size()), 8'(words.size() >> 8)};
    foreach (words[i]) for (int k = 0; k < 4; k++) fb.push_back(8'(words[i] >> (8 * k)));
    foreach (fb[i]) cs += fb[i];
    tick(1, 8'hA5);
    foreach (fb[i]) tick(1, fb[i]);
    tick(1, cs + cadj);
    if (expect_wr) foreach (words[i]) exp_q.push_back({a[11:0] + 12'(i), words[i]});
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) chk(tag, obs[i], exp_q[i]);
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    #1;
    chk("rst_we", we_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_core", core_rst_no, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", {err_o, err_code_o}, 0);
    @(posedge clk_i);
    #1 rst_ni = 1;

    words = {32'h11223344, 32'hAABBCCDD};
    send_frame(16'h0010, 8'd0, 1);
    idle(8);
    check_writes("frameA");
    chk("frameA_err", err_o, 0);
    chk("frameA_core", core_rst_no, 0);

    rnd_gnt = 1;
    for (int f = 0; f < 6; f++) begin
      words.delete();
      for (int i = 0; i < $urandom_range(1, 5); i++) words.push_back($urandom);
      send_frame(16'($urandom), 8'd0, 1);
      idle(12);
      check_writes("rand");
      chk("rand_err", err_o, 0);
    end
    rnd_gnt = 0;
    gnt_i = 1;

`ifdef BOOT_LOADER_TIMEOUT_EN
    tick(1, 8'hA5);
    tick(1, 8'h00);
    idle(30);
    chk("tmo_early", err_o, 0);
    idle(20);
    chk("tmo_err", {err_o, err_code_o}, 3'b111);
`endif

    words = {32'hCAFE0001, 32'hCAFE0002};
    send_frame(16'h0FFF, 8'd0, 1);
    idle(8);
    check_writes("wrap");

    words = {32'h11223344, 32'hAABBCCDD};
    send_frame(16'h0010, 8'd1, 1);
    #0 chk("csum_err", {err_o, err_code_o}, 3'b101);
    idle(8);
    check_writes("csum_wr");

    tick(1, 8'hA5);
    chk("sync_clear", {err_o, err_code_o}, 0);
    tick(1, 8'h00);
    tick(1, 8'h00);
    tick(1, 8'h01);
    chk("len_pre", err_o, 0);
    tick(1, 8'h10);
    chk("len_err", {err_o, err_code_o}, 3'b111);

    gnt_i = 0;
    tick(1, 8'hA5);
    tick(1, 8'h00);
    tick(1, 8'h01);
    tick(1, 8'h06);
    tick(1, 8'h00);
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 4; k++) tick(1, 8'(32'h10000000 + w >> (8 * k)));
      exp_q.push_back({12'h100 + 12'(w), 32'h10000000 + w});
    end
    chk("ovf_pre", {err_o, we_o}, 2'b01);
    for (int k = 0; k < 4; k++) tick(1, 8'(32'h10000004 >> (8 * k)));
    chk("ovf_err", {err_o, err_code_o}, 3'b110);
    for (int k = 0; k < 4; k++) tick(1, 8'(32'h10000005 >> (8 * k)));
    chk("ovf_none", 64'(obs.size()), 0);
    gnt_i = 1;
    idle(10);
    check_writes("ovf");

    gnt_i = 0;
    words = {32'h5A5A0001, 32'h5A5A0002};
    send_frame(16'h0200, 8'd0, 1);
    words.delete();
    send_frame(16'h0000, 8'd0, 0);
    idle(5);
    chk("drain_hold", {done_o, core_rst_no, we_o}, 3'b001);
    gnt_i = 1;
    for (int i = 0; i < 20 && !done_o; i++) idle(1);
    chk("boot_done", {done_o, core_rst_no, we_o}, 3'b110);
    check_writes("boot");
    words = {32'h11223344};
    send_frame(16'h0030, 8'd0, 0);
    idle(5);
    check_writes("boot_ignore");
    chk("boot_stay", {done_o, err_o}, 2'b10);

    rst_ni = 0;
    #1 rst_ni = 1;
    gnt_i = 0;
    tick(1, 8'hA5);
    tick(1, 8'h40);
    tick(1, 8'h00);
    tick(1, 8'h03);
    tick(1, 8'h00);
    for (int k = 0; k < 6; k++) tick(1, 8'h33);
    chk("mid_we", we_o, 1);
    rst_ni = 0;
    #1;
    chk("mid_rst", {we_o, addr_o, wdata_o, core_rst_no, done_o, err_o, err_code_o}, 0);
    @(posedge clk_i);
    #1 rst_ni = 1;
    gnt_i = 1;
    for (int k = 0; k < 6; k++) tick(1, 8'h33);
    idle(8);
    check_writes("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/boot_frame_loader.md
# boot_frame_loader

Framed, checksummed program loader sitting between `uart_receiver` (byte stream) and the instruction-memory write port. It parses load frames, assembles little-endian 32-bit words and buffers them in a small FIFO, then writes them to ICCM with a grant handshake. It holds the core in reset until a valid boot frame has been received and every buffered write has been retired.

## Interface
Parameters:
- `AddrW`, 12, ICCM word-address width.
- `FifoDepth`, 4, number of buffered words (power of two, ≥2).
- `TimeoutCycles`, 65535, inter-byte timeout; used only with the timeout feature.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` input 1: clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `rx_dv_i` input 1: one-cycle pulse, byte valid.
- `rx_byte_i` input 8: received byte.
- `we_o` output 1: write request to ICCM.
- `addr_o` output AddrW: word address.
- `wdata_o` output 32: write data.
- `gnt_i` input 1: write accepted this cycle.
- `core_rst_no` output 1: core reset, active-low.
- `done_o` output 1: boot released.
- `err_o` output 1: sticky error flag.
- `err_code_o` output 2: 0 none, 1 checksum, 2 overflow, 3 bad length/timeout.

## Operation
- Frame format: SYNC `0xA5`, ADDR lo, ADDR hi, LEN lo, LEN hi, then LEN×4 payload bytes (LSB first), then CSUM.
- ADDR low AddrW bits give the start word address; upper bits are ignored. LEN is a word count.
- CSUM = 8-bit sum mod 256 of every byte from ADDR lo through the last payload byte.
- FSM states: IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, CSUM, DRAIN, BOOT, ERROR. Each accepted byte advances the FSM one state, or one byte within DATA.
- In IDLE and ERROR, any byte other than 0xA5 is ignored. In ERROR, 0xA5 clears `err_o`/`err_code_o` and enters ADDR0.
- LEN1 transitions:
  - LEN > 2^AddrW: ERROR, code 3.
  - LEN == 0: CSUM (this is a boot frame).
  - Otherwise: DATA.
- DATA:
  - A byte counter (0..3) and a word counter run during DATA.
  - Each 4th byte pushes {addr, word} to the FIFO. The address then increments modulo 2^AddrW, so writes wrap.
  - After the last word, the FSM goes to CSUM.
- Overflow: a push while the FIFO is full and no pop occurs in the same cycle goes to ERROR with code 2, and the word is dropped. A push and a pop in the same cycle at full is legal.
- CSUM:
  - Mismatch: ERROR with code 1. Payload words already written stay written.
  - Match on a LEN>0 frame: IDLE.
  - Match on a LEN==0 frame: DRAIN.
- DRAIN: wait for the FIFO to empty, then go to BOOT.
- BOOT is terminal until reset. In BOOT, `core_rst_no`=1, `done_o`=1, and all rx bytes are ignored.
- The FIFO keeps draining in every state, including ERROR.
- Reset values:
  - `we_o`=0, `addr_o`=0, `wdata_o`=0.
  - `core_rst_no`=0, `done_o`=0.
  - `err_o`=0, `err_code_o`=0.
  - FSM in IDLE, FIFO empty.
- Asserting reset mid-frame or mid-drain discards everything and immediately re-asserts core reset.

## Timing
- A byte is sampled on the rising edge at which `rx_dv_i`=1. Back-to-back bytes on consecutive cycles are supported.
- Push happens on the edge of the 4th byte. `we_o`/`addr_o`/`wdata_o` show the FIFO head combinationally from registered storage, so `we_o` rises 1 cycle after that byte when the FIFO was empty.
- `we_o`=1 whenever the FIFO is non-empty. An entry pops on an edge with `we_o`&`gnt_i`. `addr_o`/`wdata_o` stay stable while `we_o`=1 and `gnt_i`=0.
- `err_o`/`err_code_o` update on the edge of the offending byte or push.
- `core_rst_no` and `done_o` rise together, one cycle after the FIFO becomes empty in DRAIN.

## Configuration
- Macro `BOOT_LOADER_TIMEOUT_EN`.
- Defined:
  - A counter resets on every accepted byte and counts only in ADDR0..CSUM.
  - Reaching TimeoutCycles goes to ERROR with code 3 and abandons the frame.
- Undefined: no counter and no timeout logic. A stalled frame waits indefinitely. `TimeoutCycles` is unused.

## Structure
- `boot_loader_pkg` holds:
  - the FSM state enum;
  - `SYNC_BYTE`=8'hA5;
  - error-code localparams;
  - the FIFO entry struct {addr, data}.
- Sub-module `boot_word_fifo`: a parameterised synchronous FIFO with push/pop/full/empty and a head-output view. The top contains the parser FSM, the counters and the checksum accumulator.

## Test plan
- Frame A5 10 00 02 00 + words 0x11223344, 0xAABBCCDD + correct CSUM, `gnt_i`=1 → writes (0x010, 0x11223344) then (0x011, 0xAABBCCDD); `err_o`=0; `core_rst_no`=0.
- Same frame with CSUM+1 → `err_o`=1, code 1. Both words are still written. A following valid boot frame A5 00 00 00 00 00 → `done_o`=1 and `core_rst_no`=1 after the FIFO drains.
- ADDR=0xFFF, LEN=2 → writes to 0xFFF then 0x000 (wrap).
- `gnt_i` held at 0 while a 6-word frame streams back-to-back → 4 writes queued, then the 5th push gives code 2. Releasing `gnt_i` drains exactly 4 writes in order.
- LEN=0x1001 → ERROR, code 3, at the LEN hi byte. With `BOOT_LOADER_TIMEOUT_EN`, stopping after ADDR0 for TimeoutCycles → code 3 and the FSM returns to accepting SYNC.
- Reset asserted mid-DATA → all outputs at reset values on the same edge, FIFO empty, no further writes issued.
